// File: rtl/jpeb_pkg.sv
// Shared definitions for the JPEB pipeline slice: opcode encodings,
// register-index width and the opcode-class helper used by writeback.
package jpeb_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_W-1:0] OP_LUI  = 3'b011;
  localparam logic [OP_W-1:0] OP_SW   = 3'b100;
  localparam logic [OP_W-1:0] OP_LW   = 3'b101;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b110;
  localparam logic [OP_W-1:0] OP_JALR = 3'b111;

  // True for opcodes that produce a register result (everything but SW/BEQ).
  function automatic logic writes_reg(input logic [OP_W-1:0] op);
    return !((op == OP_SW) || (op == OP_BEQ));
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Memory-stage -> writeback slot bundle.
//   bubble : slot carries no instruction
//   opcode : opcode of the instruction in the slot
//   tgt    : destination register index
//   result : value to commit
//   halt   : instruction in the slot is a halt
// master = memory stage (drives), slave = writeback (consumes).
interface writeback_if #(
  parameter int unsigned DATA_W = 16
);
  import jpeb_pkg::*;

  logic                 bubble;
  logic [OP_W-1:0]      opcode;
  logic [REG_IDX_W-1:0] tgt;
  logic [DATA_W-1:0]    result;
  logic                 halt;

  modport master (output bubble, opcode, tgt, result, halt);
  modport slave  (input  bubble, opcode, tgt, result, halt);

endinterface

// File: rtl/wb_regfile.sv
// Register file: NREGS x DATA_W, one write port, two combinational read
// ports. r0 is hardwired to zero and never written. A read of the register
// being written this cycle returns the incoming write data.
//   clk, rst_n : clock, async active-low reset (clears all entries)
//   we, wa, wd : write enable / address / data (commits at rising edge)
//   ra0, ra1   : read addresses
//   rd0, rd1   : read data
module wb_regfile
  import jpeb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [DATA_W-1:0]    wd,
  input  logic [REG_IDX_W-1:0] ra0,
  input  logic [REG_IDX_W-1:0] ra1,
  output logic [DATA_W-1:0]    rd0,
  output logic [DATA_W-1:0]    rd1
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd0 = '0;
    if (ra0 != '0) begin
      rd0 = (we && (wa == ra0)) ? wd : regs[ra0];
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    end
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage. Commits memory-stage results to the register file,
// serves two decode read ports, and drives a one-cycle forwarding record,
// a sticky halted flag and a saturating retired-instruction counter.
//   clk, rst_n          : clock, async active-low reset
//   mem                 : incoming slot (writeback_if.slave)
//   ra0, ra1 / rd0, rd1 : decode read ports (combinational, with bypass)
//   fwd_valid/tgt/data  : registered record of last cycle's register write
//   halted              : sticky, set once a halt retires
//   retired             : retired instruction count, saturating
module writeback
  import jpeb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_if.slave           mem,
  input  logic [REG_IDX_W-1:0] ra0,
  input  logic [REG_IDX_W-1:0] ra1,
  output logic [DATA_W-1:0]    rd0,
  output logic [DATA_W-1:0]    rd1,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_tgt,
  output logic [DATA_W-1:0]    fwd_data,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  logic valid;
  logic we;

  // Once halted, every later slot is dropped, bubble or not. A halt slot
  // never writes even if its opcode is a writer.
  always_comb begin
    valid = !mem.bubble && !halted;
    we    = valid && !mem.halt && writes_reg(mem.opcode) && (mem.tgt != '0);
  end

  wb_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (mem.tgt),
    .wd    (mem.result),
    .ra0   (ra0),
    .ra1   (ra1),
    .rd0   (rd0),
    .rd1   (rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_tgt   <= '0;
      fwd_data  <= '0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      fwd_valid <= we;
      fwd_tgt   <= we ? mem.tgt    : '0;
      fwd_data  <= we ? mem.result : '0;
      if (valid && mem.halt) begin
        halted <= 1'b1;
      end
      if (valid && (retired != '1)) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback. Slots come from a vector table and a
// few hand-written sequences; combinational reads are checked in-slot
// against constants, registered outputs are checked after the edge against
// records pushed by an independent reference model.
module tb_writeback;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic        bubble;
    logic [2:0]  op;
    logic [2:0]  tgt;
    logic [15:0] res;
    logic        halt;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;
  } vec_t;

  typedef struct packed {
    logic        fwd_valid;
    logic [2:0]  fwd_tgt;
    logic [15:0] fwd_data;
    logic        halted;
    logic [31:0] retired;
    logic [3:0]  retired4;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  writeback_if #(.DATA_W(DATA_W)) mem ();

  logic [2:0]  ra0, ra1;
  logic [15:0] rd0, rd1, s_rd0, s_rd1;
  logic        fwd_valid, s_fwd_valid;
  logic [2:0]  fwd_tgt, s_fwd_tgt;
  logic [15:0] fwd_data, s_fwd_data;
  logic        halted, s_halted;
  logic [31:0] retired;
  logic [3:0]  retired4;

  writeback #(.DATA_W(DATA_W), .NREGS(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem), .ra0(ra0), .ra1(ra1),
    .rd0(rd0), .rd1(rd1), .fwd_valid(fwd_valid), .fwd_tgt(fwd_tgt),
    .fwd_data(fwd_data), .halted(halted), .retired(retired)
  );

  writeback #(.DATA_W(DATA_W), .NREGS(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem(mem), .ra0(ra0), .ra1(ra1),
    .rd0(s_rd0), .rd1(s_rd1), .fwd_valid(s_fwd_valid), .fwd_tgt(s_fwd_tgt),
    .fwd_data(s_fwd_data), .halted(s_halted), .retired(retired4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] mregs [8];
  logic        mhalted;
  logic [31:0] mret;
  logic [3:0]  mret4;
  exp_t        sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic b, input logic [2:0] op, input logic [2:0] tgt,
                              input logic [15:0] res, input logic h, input logic [2:0] a0,
                              input logic [2:0] a1, input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.bubble = b; v.op = op; v.tgt = tgt; v.res = res; v.halt = h;
    v.ra0 = a0; v.ra1 = a1; v.exp_rd0 = e0; v.exp_rd1 = e1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mhalted = 1'b0;
    mret    = '0;
    mret4   = '0;
    sb.delete();
  endtask

  // One slot: drive after the falling edge, check reads mid-cycle, model the
  // edge, then compare registered outputs just after the rising edge.
  task automatic drive_slot(input vec_t v, input string tag);
    exp_t e, got;
    logic mvalid, mwe;
    @(negedge clk);
    mem.bubble = v.bubble; mem.opcode = v.op; mem.tgt = v.tgt;
    mem.result = v.res;    mem.halt = v.halt;
    ra0 = v.ra0; ra1 = v.ra1;
    #1;
    check({tag, ".rd0"}, 32'(rd0), 32'(v.exp_rd0));
    check({tag, ".rd1"}, 32'(rd1), 32'(v.exp_rd1));
    mvalid = !v.bubble && !mhalted;
    mwe    = mvalid && !v.halt && !(v.op == 3'b100 || v.op == 3'b110) && (v.tgt != 3'd0);
    if (mwe) mregs[v.tgt] = v.res;
    if (mvalid && v.halt) mhalted = 1'b1;
    if (mvalid && mret != 32'hFFFF_FFFF) mret = mret + 1;
    if (mvalid && mret4 != 4'hF) mret4 = mret4 + 1;
    e.fwd_valid = mwe;
    e.fwd_tgt   = mwe ? v.tgt : 3'd0;
    e.fwd_data  = mwe ? v.res : 16'd0;
    e.halted    = mhalted;
    e.retired   = mret;
    e.retired4  = mret4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      got.fwd_valid = fwd_valid; got.fwd_tgt = fwd_tgt; got.fwd_data = fwd_data;
      got.halted = halted; got.retired = retired; got.retired4 = retired4;
      check({tag, ".fwd_valid"}, 32'(got.fwd_valid), 32'(e.fwd_valid));
      check({tag, ".fwd_tgt"},   32'(got.fwd_tgt),   32'(e.fwd_tgt));
      check({tag, ".fwd_data"},  32'(got.fwd_data),  32'(e.fwd_data));
      check({tag, ".halted"},    32'(got.halted),    32'(e.halted));
      check({tag, ".retired"},   got.retired,        e.retired);
      check({tag, ".retired4"},  32'(got.retired4),  32'(e.retired4));
    end
  endtask

  // Assert reset just after a falling edge and check everything cleared
  // before the next rising edge arrives.
  task automatic reset_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    mem.bubble = 1'b1;
    model_reset();
    #1;
    check({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
    check({tag, ".fwd_tgt"},   32'(fwd_tgt),   32'd0);
    check({tag, ".fwd_data"},  32'(fwd_data),  32'd0);
    check({tag, ".halted"},    32'(halted),    32'd0);
    check({tag, ".retired"},   retired,        32'd0);
    check({tag, ".retired4"},  32'(retired4),  32'd0);
    for (int i = 0; i < 4; i++) begin
      ra0 = 3'(i); ra1 = 3'(i + 4);
      #1;
      check({tag, ".rd0"}, 32'(rd0), 32'd0);
      check({tag, ".rd1"}, 32'(rd1), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 3'b000, 3, 16'h1234, 0, 3, 0, 16'h1234, 16'h0000); // ADD bypass
    tbl[1]  = mk(1, 3'b000, 0, 16'h0000, 0, 3, 5, 16'h1234, 16'h0000); // r3 committed
    tbl[2]  = mk(0, 3'b101, 5, 16'hBEEF, 0, 3, 5, 16'h1234, 16'hBEEF); // LW bypass
    tbl[3]  = mk(0, 3'b100, 2, 16'hAAAA, 0, 2, 5, 16'h0000, 16'hBEEF); // SW
    tbl[4]  = mk(0, 3'b110, 2, 16'h5555, 0, 2, 0, 16'h0000, 16'h0000); // BEQ
    tbl[5]  = mk(0, 3'b001, 0, 16'hFFFF, 0, 0, 2, 16'h0000, 16'h0000); // ADDI r0
    tbl[6]  = mk(1, 3'b000, 2, 16'h1111, 0, 2, 2, 16'h0000, 16'h0000); // bubble ADD
    tbl[7]  = mk(0, 3'b010, 7, 16'h00F0, 0, 7, 2, 16'h00F0, 16'h0000); // NAND
    tbl[8]  = mk(0, 3'b011, 6, 16'hAB00, 0, 6, 7, 16'hAB00, 16'h00F0); // LUI
    tbl[9]  = mk(0, 3'b111, 1, 16'h0042, 0, 1, 6, 16'h0042, 16'hAB00); // JALR
    tbl[10] = mk(0, 3'b000, 3, 16'h9999, 0, 3, 3, 16'h9999, 16'h9999); // overwrite
    tbl[11] = mk(1, 3'b000, 0, 16'h0000, 0, 3, 5, 16'h9999, 16'hBEEF);

    rst_n = 1'b0;
    mem.bubble = 1'b1; mem.opcode = '0; mem.tgt = '0; mem.result = '0; mem.halt = 1'b0;
    ra0 = '0; ra1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init.fwd_valid", 32'(fwd_valid), 32'd0);
    check("init.halted",    32'(halted),    32'd0);
    check("init.retired",   retired,        32'd0);
    rst_n = 1'b1;

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      drive_slot(mk(0, 3'b000, 1, 16'(i + 1), 0, 1, 0, 16'(i + 1), 16'h0000), "sat");
    end
    check("sat.final4", 32'(retired4), 32'd15);
    check("sat.final32", retired, 32'd20);

    reset_and_check("rst1");
    drive_slot(mk(0, 3'b000, 1, 16'hABCD, 0, 1, 0, 16'hABCD, 16'h0000), "post_rst1");
    check("post_rst1.retired4", 32'(retired4), 32'd1);

    for (int i = 0; i < 12; i++) begin
      drive_slot(tbl[i], $sformatf("tbl%0d", i));
    end

    // Halt with a writer opcode: no write, counted, then everything frozen
    drive_slot(mk(0, 3'b000, 4, 16'h0007, 1, 4, 0, 16'h0000, 16'h0000), "halt");
    check("halt.flag", 32'(halted), 32'd1);
    drive_slot(mk(0, 3'b000, 4, 16'h0077, 0, 4, 3, 16'h0000, 16'h9999), "after_halt");
    drive_slot(mk(1, 3'b000, 0, 16'h0000, 0, 4, 5, 16'h0000, 16'hBEEF), "halt_r4");

    reset_and_check("rst2");
    drive_slot(mk(0, 3'b000, 2, 16'h2222, 0, 2, 0, 16'h2222, 16'h0000), "post_rst2");
    drive_slot(mk(1, 3'b000, 0, 16'h0000, 0, 2, 3, 16'h2222, 16'h0000), "post_rst2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
